led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 42 ++++
 rtl/led_seq_prescaler.sv | 26 ++
 rtl/led_seq_ctrl.sv | 107 ++++++++++
 tb/tb_led_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and LED pattern constants for the LED sequencer.
// The step helpers give the first pattern of each mode and the pattern that follows a given one.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] LED_OFF     = 2'b00;
  localparam logic [1:0] BLINK_ON    = 2'b11;
  localparam logic [1:0] BLINK_OFF   = 2'b00;
  localparam logic [1:0] CHASE_A     = 2'b01;
  localparam logic [1:0] CHASE_B     = 2'b10;
  localparam logic [1:0] COUNT_START = 2'b00;

  function automatic logic [1:0] first_step(input mode_e m);
    case (m)
      MODE_BLINK: return BLINK_ON;
      MODE_CHASE: return CHASE_A;
      MODE_COUNT: return COUNT_START;
      default:    return LED_OFF;
    endcase
  endfunction

  function automatic logic [1:0] next_step(input mode_e m, input logic [1:0] cur);
    case (m)
      MODE_BLINK: return (cur == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      MODE_CHASE: return (cur == CHASE_A) ? CHASE_B : CHASE_A;
      MODE_COUNT: return cur + 2'd1;
      default:    return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler: emits a one-cycle tick every DIV enabled cycles.
// Held at zero while disabled; clr restarts the count from the current cycle.
module led_seq_prescaler #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr || !en || tick)  cnt <= '0;
    else                          cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: accepts mode requests and steps a 2-bit LED pattern every DIV cycles.
// Define LED_SEQ_ONESHOT_EN to end each run after REPEAT steps with a done pulse.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DIV    = 25,
  parameter int REPEAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  output logic       mode_ack,
  output logic [1:0] next_led,
  output logic       busy,
  output logic       done
);

  state_e     state, state_d;
  mode_e      mode, mode_d, sel;
  logic [1:0] led_d;
  logic       accept, tick, run;

  // A request is taken only when no ack is outstanding, so a held request acks every other cycle.
  assign accept = mode_req && !mode_ack;
  assign sel    = mode_e'(mode_sel);
  assign run    = (state == ST_RUN);
  assign busy   = run;

  led_seq_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (run),
    .tick (tick)
  );

`ifdef LED_SEQ_ONESHOT_EN
  localparam int SW = $clog2(REPEAT + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(REPEAT - 1);

  logic [SW-1:0] steps, steps_d;
  logic          done_d;
`endif

  always_comb begin
    state_d = state;
    mode_d  = mode;
    led_d   = next_led;
`ifdef LED_SEQ_ONESHOT_EN
    steps_d = steps;
    done_d  = 1'b0;
`endif
    if (accept) begin
      // A new request wins over a same-cycle tick; that tick is dropped.
      mode_d  = sel;
      led_d   = first_step(sel);
      state_d = (sel == MODE_OFF) ? ST_IDLE : ST_RUN;
`ifdef LED_SEQ_ONESHOT_EN
      steps_d = '0;
`endif
    end else if (tick) begin
`ifdef LED_SEQ_ONESHOT_EN
      if (steps == LAST_STEP) begin
        state_d = ST_IDLE;
        led_d   = LED_OFF;
        done_d  = 1'b1;
        steps_d = '0;
      end else begin
        steps_d = steps + SW'(1);
        led_d   = next_step(mode, next_led);
      end
`else
      led_d = next_step(mode, next_led);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      mode     <= MODE_OFF;
      next_led <= LED_OFF;
      mode_ack <= 1'b0;
    end else begin
      state    <= state_d;
      mode     <= mode_d;
      next_led <= led_d;
      mode_ack <= accept;
    end
  end

`ifdef LED_SEQ_ONESHOT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steps <= '0;
      done  <= 1'b0;
    end else begin
      steps <= steps_d;
      done  <= done_d;
    end
  end
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with DIV=4, directed scenarios plus random requests.
// The reference model tracks cycles since the last ack and derives the pattern index arithmetically.
module tb_led_seq_ctrl;

  localparam int DIV = 4;
`ifdef LED_SEQ_ONESHOT_EN
  localparam int REPEAT  = 3;
  localparam bit ONESHOT = 1'b1;
`else
  localparam int REPEAT  = 8;
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_req = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_ack;
  logic [1:0] next_led;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  bit         m_ack, m_run, m_done;
  int         m_mode, m_cyc;
  logic [1:0] m_led;

  always #5 clk = ~clk;

  led_seq_ctrl #(.DIV(DIV), .REPEAT(REPEAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .mode_sel (mode_sel),
    .mode_ack (mode_ack),
    .next_led (next_led),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [1:0] pattern(input int mode, input int k);
    case (mode)
      1:       return (k % 2 == 0) ? 2'b11 : 2'b00;
      2:       return (k % 2 == 0) ? 2'b01 : 2'b10;
      3:       return 2'(k % 4);
      default: return 2'b00;
    endcase
  endfunction

  function automatic void model_reset();
    m_ack = 0; m_run = 0; m_done = 0; m_mode = 0; m_cyc = 0; m_led = 2'b00;
  endfunction

  function automatic void model_edge(input bit req, input int sel);
    m_done = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (req && !m_ack) begin
      m_ack = 1; m_mode = sel; m_cyc = 0; m_run = (sel != 0);
    end else begin
      m_ack = 0;
      if (m_run) begin
        m_cyc++;
        if (ONESHOT && m_cyc == DIV * REPEAT) begin
          m_run = 0; m_done = 1;
        end
      end
    end
    m_led = m_run ? pattern(m_mode, m_cyc / DIV) : 2'b00;
  endfunction

  task automatic step(input bit req, input logic [1:0] sel);
    mode_req = req;
    mode_sel = sel;
    @(posedge clk);
    model_edge(req, int'(sel));
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({mode_ack, busy, done, next_led} !== 5'b0) begin
      failures++; $display("FAIL reset_initial got=%b exp=00000", {mode_ack, busy, done, next_led});
    end
    step(0, 0); step(0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      checks++;
      if (next_led !== 2'b00 || busy !== 1'b0) begin
        failures++; $display("FAIL reset_idle got led=%b busy=%b exp led=00 busy=0", next_led, busy);
      end
    end
    step(1, 1);
    for (int i = 0; i < 5; i++) step(0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({mode_ack, busy, done, next_led} !== 5'b0) begin
      failures++; $display("FAIL reset_async got=%b exp=00000", {mode_ack, busy, done, next_led});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      checks++;
      if ({mode_ack, busy, done, next_led} !== 5'b0) begin
        failures++; $display("FAIL reset_held got=%b exp=00000", {mode_ack, busy, done, next_led});
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led} || next_led !== 2'b00) begin
        failures++; $display("FAIL reset_release got=%b exp=%b", {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
    end
  endtask

  task automatic test_blink();
    step(1, 2'd1);
    checks++;
    if (mode_ack !== 1'b1 || next_led !== 2'b11 || busy !== 1'b1) begin
      failures++; $display("FAIL blink_ack got ack=%b led=%b busy=%b exp ack=1 led=11 busy=1", mode_ack, next_led, busy);
    end
    for (int i = 1; i <= 10; i++) begin
      step(0, 0);
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL blink_model i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
      if (i == 4 || i == 8) begin
        checks++;
        if (next_led !== ((i == 4) ? 2'b00 : 2'b11)) begin
          failures++; $display("FAIL blink_step i=%0d got=%b exp=%b", i, next_led, (i == 4) ? 2'b00 : 2'b11);
        end
      end
    end
  endtask

  task automatic test_count();
    logic [1:0] exp;
    step(1, 2'd3);
    checks++;
    if (mode_ack !== 1'b1 || next_led !== 2'b00) begin
      failures++; $display("FAIL count_ack got ack=%b led=%b exp ack=1 led=00", mode_ack, next_led);
    end
    for (int i = 1; i <= 17; i++) begin
      step(0, 0);
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL count_model i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
      if (i % 4 == 0) begin
        exp = (ONESHOT && i >= DIV * REPEAT) ? 2'b00 : 2'((i / 4) % 4);
        checks++;
        if (next_led !== exp) begin
          failures++; $display("FAIL count_step i=%0d got=%b exp=%b", i, next_led, exp);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    logic [1:0] exp;
    step(1, 2'd2);
    step(0, 0);
    step(1, 2'd3);
    checks++;
    if (mode_ack !== 1'b1 || next_led !== 2'b00) begin
      failures++; $display("FAIL midchg_ack got ack=%b led=%b exp ack=1 led=00", mode_ack, next_led);
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 0);
      exp = (i >= 4) ? 2'b01 : 2'b00;
      checks++;
      if (next_led !== exp || {mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL midchg_step i=%0d got=%b exp led=%b model=%b", i, {mode_ack, busy, done, next_led}, exp, {m_ack, m_run, m_done, m_led});
      end
    end
  endtask

  task automatic test_held();
    int acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 2'd1);
      if (mode_ack === 1'b1) acks++;
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL held_model i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
    end
    checks++;
    if (acks != 3) begin
      failures++; $display("FAIL held_ack_count got=%0d exp=3", acks);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL held_after i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
    end
  endtask

`ifdef LED_SEQ_ONESHOT_EN
  task automatic test_oneshot();
    int dones = 0;
    step(1, 2'd1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0);
      if (done === 1'b1) dones++;
      checks++;
      if (done !== (i == 12) || {mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL oneshot_step i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
    end
    checks++;
    if (dones != 1 || busy !== 1'b0 || next_led !== 2'b00) begin
      failures++; $display("FAIL oneshot_end got dones=%0d busy=%b led=%b exp 1 0 00", dones, busy, next_led);
    end
  endtask
`endif

  task automatic test_random();
    bit         req;
    logic [1:0] sel;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 5) == 0);
      sel = 2'($urandom_range(0, 3));
      step(req, sel);
      checks++;
      if ({mode_ack, busy, done, next_led} !== {m_ack, m_run, m_done, m_led}) begin
        failures++; $display("FAIL random_model i=%0d got=%b exp=%b", i, {mode_ack, busy, done, next_led}, {m_ack, m_run, m_done, m_led});
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_count();
    test_mid_change();
    test_held();
`ifdef LED_SEQ_ONESHOT_EN
    test_oneshot();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
